// File: rtl/vic_prio_wb.sv
// Vectored interrupt controller with fixed priority and a Wishbone-style vector read.
//
// Requests on ireq are collected into a pending register. The highest-index pending,
// unmasked channel wins. A CPU vector read (wb_stb_i) walks the acknowledge FSM
// IDLE -> LATCH -> ACK -> WAIT_DROP. The winner is frozen on entry to LATCH, its vector
// (or SPUR_VEC when nothing was pending) is presented with wb_ack_o, and a one-cycle
// iack pulse goes to the winning channel.
//
// Build option: define VIC_EDGE_EN to pend on 0->1 ireq transitions instead of on level.
//
// Ports:
//   clk_sys   system clock
//   wb_rst_i  synchronous active-high reset (acts regardless of ce)
//   ce        clock enable for all state except the iack pulse
//   ivec      16-bit vector per channel, channel k at [16k+15:16k]
//   ireq      request per channel
//   iack      one clk_sys pulse to the acknowledged channel
//   mask_we   mask write strobe
//   mask_din  mask write data, 1 blocks a channel
//   mask_q    current mask
//   wb_irq_o  registered interrupt request to the CPU
//   wb_stb_i  vector read strobe
//   wb_dat_o  vector data, zero whenever wb_ack_o is low
//   wb_ack_o  vector read reply
module vic_prio_wb #(
    parameter int unsigned N        = 4,
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input  logic            clk_sys,
    input  logic            wb_rst_i,
    input  logic            ce,
    input  logic [16*N-1:0] ivec,
    input  logic [N-1:0]    ireq,
    output logic [N-1:0]    iack,
    input  logic            mask_we,
    input  logic [N-1:0]    mask_din,
    output logic [N-1:0]    mask_q,
    output logic            wb_irq_o,
    input  logic            wb_stb_i,
    output logic [15:0]     wb_dat_o,
    output logic            wb_ack_o
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StLatch, StAck, StWaitDrop} state_e;

    state_e          state_q;
    logic [N-1:0]    pend_q;
    logic [N-1:0]    pend_set;
    logic [N-1:0]    pend_clr;
    logic [N-1:0]    avail;
    logic [N-1:0]    sel_onehot;
    logic [IdxW-1:0] win_idx;
    logic            win_valid;
    logic [IdxW-1:0] sel_q;
    logic            valid_q;
    logic            irq_q;
    logic            ack_q;
    logic [15:0]     dat_q;
    logic [N-1:0]    iack_q;
    logic            ack_fire;

`ifdef VIC_EDGE_EN
    logic [N-1:0] ireq_hist_q;

    always_ff @(posedge clk_sys) begin
        if (wb_rst_i) begin
            ireq_hist_q <= '0;
        end else if (ce) begin
            ireq_hist_q <= ireq;
        end
    end

    assign pend_set = ireq & ~ireq_hist_q;
`else
    assign pend_set = ireq;
`endif

    assign avail = pend_q & ~mask_q;

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (avail[k]) begin
                win_valid = 1'b1;
                win_idx   = IdxW'(k);
            end
        end
    end

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[sel_q] = 1'b1;
    end

    // LATCH -> ACK transition with a real winner: pulse iack and retire the pend bit.
    assign ack_fire = ce && (state_q == StLatch) && wb_stb_i && valid_q;
    assign pend_clr = ack_fire ? sel_onehot : '0;

    always_ff @(posedge clk_sys) begin
        if (wb_rst_i) begin
            pend_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else if (ce) begin
            // Set wins over clear in the same cycle.
            pend_q <= (pend_q & ~pend_clr) | pend_set;
            irq_q  <= |avail;
            if (mask_we) begin
                mask_q <= mask_din;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            iack_q  <= '0;
        end else begin
            // iack is a single clk_sys pulse, independent of ce.
            iack_q <= '0;
            if (ce) begin
                case (state_q)
                    StIdle: begin
                        if (wb_stb_i) begin
                            state_q <= StLatch;
                            sel_q   <= win_idx;
                            valid_q <= win_valid;
                        end
                    end
                    StLatch: begin
                        if (!wb_stb_i) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StAck;
                            ack_q   <= 1'b1;
                            dat_q   <= valid_q ? ivec[{sel_q, 4'b0000} +: 16] : SPUR_VEC;
                            if (valid_q) begin
                                iack_q <= sel_onehot;
                            end
                        end
                    end
                    StAck: begin
                        state_q <= StWaitDrop;
                    end
                    StWaitDrop: begin
                        if (!wb_stb_i) begin
                            state_q <= StIdle;
                            ack_q   <= 1'b0;
                            dat_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign iack     = iack_q;
    assign wb_irq_o = irq_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_vic_prio_wb.sv
module tb_vic_prio_wb;

    localparam logic [15:0] Spur = 16'o000777;

    logic        clk_sys = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] ivec = {16'o000060, 16'o000274};
    logic [1:0]  ireq = 2'b00;
    logic [1:0]  iack;
    logic        mask_we = 1'b0;
    logic [1:0]  mask_din = 2'b00;
    logic [1:0]  mask_q;
    logic        wb_irq_o;
    logic        wb_stb_i = 1'b0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    int n_checks = 0;
    int n_fail   = 0;
    int div      = 1;

    // Scoreboard entries: {vector, iack}
    logic [17:0] exp_q[$];
    logic [17:0] e;
    logic        ack_prev = 1'b0;
    int          iack_run = 0;

    vic_prio_wb #(
        .N        (2),
        .SPUR_VEC (Spur)
    ) dut (
        .clk_sys  (clk_sys),
        .wb_rst_i (wb_rst_i),
        .ce       (ce),
        .ivec     (ivec),
        .ireq     (ireq),
        .iack     (iack),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .mask_q   (mask_q),
        .wb_irq_o (wb_irq_o),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each rising ack, polices iack width and idle data.
    always @(negedge clk_sys) begin
        if (wb_ack_o && !ack_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_dat", {16'd0, wb_dat_o}, {16'd0, e[17:2]});
                check("ack_iack", {30'd0, iack}, {30'd0, e[1:0]});
            end
        end else if (iack != 2'b00) begin
            check("iack_outside_ack", {30'd0, iack}, 32'd0);
        end
        if (iack != 2'b00) begin
            iack_run++;
        end else begin
            if (iack_run != 0) check("iack_width", iack_run, 32'd1);
            iack_run = 0;
        end
        if (!wb_ack_o) check("dat_idle_zero", {16'd0, wb_dat_o}, 32'd0);
        ack_prev = wb_ack_o;
    end

    // One ce edge, then div-1 clocks with ce low.
    task automatic step();
        ce = 1'b1;
        @(posedge clk_sys);
        #1;
        ce = 1'b0;
        repeat (div - 1) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic ack_cycle(input logic [15:0] d, input logic [1:0] ia);
        exp_q.push_back({d, ia});
        wb_stb_i = 1'b1;
        step();
        step();
        check("ack_high", {31'd0, wb_ack_o}, 32'd1);
        step();
        check("ack_held", {31'd0, wb_ack_o}, 32'd1);
        wb_stb_i = 1'b0;
        step();
        check("ack_drop", {31'd0, wb_ack_o}, 32'd0);
        check("dat_drop", {16'd0, wb_dat_o}, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        wb_stb_i = 1'b0;
        @(posedge clk_sys);
        #1;
        wb_rst_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd0);
        check({tag, "_dat"}, {16'd0, wb_dat_o}, 32'd0);
        check({tag, "_iack"}, {30'd0, iack}, 32'd0);
        check({tag, "_irq"}, {31'd0, wb_irq_o}, 32'd0);
        check({tag, "_mask"}, {30'd0, mask_q}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_sys);
        #1;
        wb_rst_i = 1'b0;
        check_all_zero("reset");

        // Both channels request; channel 1 first, then channel 0.
        ireq = 2'b11;
        step();
        ireq = 2'b00;
        step();
        check("irq_both", {31'd0, wb_irq_o}, 32'd1);
        ack_cycle(16'o000060, 2'b10);
        ack_cycle(16'o000274, 2'b01);
        check("irq_clear", {31'd0, wb_irq_o}, 32'd0);

        // Nothing pending: spurious vector, no iack.
        ack_cycle(Spur, 2'b00);

        // Mask blocks irq but keeps pend.
        mask_we  = 1'b1;
        mask_din = 2'b10;
        step();
        mask_we = 1'b0;
        check("mask_q", {30'd0, mask_q}, 32'd2);
        ireq = 2'b10;
        step();
        ireq = 2'b00;
        step();
        step();
        check("irq_masked", {31'd0, wb_irq_o}, 32'd0);
        mask_we  = 1'b1;
        mask_din = 2'b00;
        step();
        mask_we = 1'b0;
        step();
        check("irq_unmasked", {31'd0, wb_irq_o}, 32'd1);
        ack_cycle(16'o000060, 2'b10);
        step();
        check("irq_after_mask_ack", {31'd0, wb_irq_o}, 32'd0);

        // Higher-priority request during LATCH must not steal the selection.
        ireq = 2'b01;
        step();
        ireq = 2'b00;
        exp_q.push_back({16'o000274, 2'b01});
        wb_stb_i = 1'b1;
        step();
        ireq = 2'b10;
        step();
        ireq = 2'b00;
        step();
        wb_stb_i = 1'b0;
        step();
        check("late_req_ack_drop", {31'd0, wb_ack_o}, 32'd0);
        ack_cycle(16'o000060, 2'b10);

        // Strobe dropped in LATCH: no ack, pend kept.
        ireq = 2'b01;
        step();
        ireq = 2'b00;
        wb_stb_i = 1'b1;
        step();
        wb_stb_i = 1'b0;
        step();
        check("abort_no_ack", {31'd0, wb_ack_o}, 32'd0);
        step();
        check("abort_no_ack2", {31'd0, wb_ack_o}, 32'd0);
        ack_cycle(16'o000274, 2'b01);

        // Reset in LATCH with ce low: aborts, clears pend.
        ireq = 2'b01;
        step();
        ireq = 2'b00;
        wb_stb_i = 1'b1;
        step();
        do_reset();
        check_all_zero("rst_latch");
        ack_cycle(Spur, 2'b00);

        // Reset during ACK: all outputs zero on the next clock.
        ireq = 2'b01;
        step();
        ireq = 2'b00;
        exp_q.push_back({16'o000274, 2'b01});
        wb_stb_i = 1'b1;
        step();
        step();
        check("pre_rst_ack", {31'd0, wb_ack_o}, 32'd1);
        do_reset();
        check_all_zero("rst_ack");

        // Held level on channel 0.
        ireq = 2'b01;
        step();
        step();
        check("held_irq", {31'd0, wb_irq_o}, 32'd1);
        ack_cycle(16'o000274, 2'b01);
        step();
`ifdef VIC_EDGE_EN
        check("held_irq_after_ack", {31'd0, wb_irq_o}, 32'd0);
`else
        check("held_irq_after_ack", {31'd0, wb_irq_o}, 32'd1);
`endif
        do_reset();
        step();
        step();
        check("repend_after_rst", {31'd0, wb_irq_o}, 32'd1);
        ireq = 2'b00;
        do_reset();

        // Slow clock enable: one ce every 24 clocks.
        div  = 24;
        ireq = 2'b01;
        repeat (5) @(posedge clk_sys);
        #1;
        ireq = 2'b00;
        step();
        step();
        check("no_ce_no_pend", {31'd0, wb_irq_o}, 32'd0);
        ireq = 2'b11;
        step();
        ireq = 2'b00;
        step();
        check("slow_irq", {31'd0, wb_irq_o}, 32'd1);
        wb_stb_i = 1'b1;
        repeat (30) @(posedge clk_sys);
        #1;
        check("slow_no_ack_without_ce", {31'd0, wb_ack_o}, 32'd0);
        wb_stb_i = 1'b0;
        ack_cycle(16'o000060, 2'b10);
        ack_cycle(16'o000274, 2'b01);
        check("slow_irq_clear", {31'd0, wb_irq_o}, 32'd0);

        repeat (2) @(posedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vic_prio_wb.md
VIC_PRIO_WB -- requirements
Module: vic_prio_wb

Interface
REQ-001 Parameter N, default 4: number of interrupt channels, 1..16.
REQ-002 Parameter SPUR_VEC, default 16'o000000: vector returned when an acknowledge cycle finds nothing pending.
REQ-003 clk_sys  in  1  system clock; single clock domain.
REQ-004 wb_rst_i  in  1  synchronous, active-high reset, sampled on clk_sys rising edge.
REQ-005 ce  in  1  clock enable; all state except iack pulses advances only when ce=1.
REQ-006 ivec  in  16*N  vector per channel; channel k at bits [16k+15:16k].
REQ-007 ireq  in  N  request per channel.
REQ-008 iack  out  N  one clk_sys pulse to the channel being acknowledged.
REQ-009 mask_we  in  1  mask register write strobe.
REQ-010 mask_din  in  N  mask data; bit=1 blocks that channel.
REQ-011 mask_q  out  N  current mask register.
REQ-012 wb_irq_o  out  1  interrupt request to CPU.
REQ-013 wb_stb_i  in  1  vector-read strobe (IAKO and bus strobe).
REQ-014 wb_dat_o  out  16  vector data.
REQ-015 wb_ack_o  out  1  reply.

Function
REQ-016 pend[k] SHALL set on an ireq[k] event, per REQ-033/034, and SHALL clear only when channel k is acknowledged.
REQ-017 If pend[k] sets and clears in the same ce cycle, set SHALL win.
REQ-018 The highest index SHALL have the highest priority among pend & ~mask_q.
REQ-019 wb_irq_o SHALL be registered: 1 on the ce cycle after |(pend & ~mask_q) becomes true.
REQ-020 A mask write SHALL apply on the same ce cycle; masking SHALL NOT clear pend.
REQ-021 The FSM SHALL have the states IDLE, LATCH, ACK, and WAIT_DROP.
REQ-022 IDLE->LATCH: on the ce cycle where wb_stb_i=1 is first seen.
REQ-023 LATCH: freeze the winner index into sel and set a valid flag. If no channel is unmasked and pending, valid=0.
REQ-024 LATCH->ACK: after exactly one ce cycle. wb_dat_o SHALL be ivec[sel] if valid, else SPUR_VEC.
REQ-025 In ACK, wb_ack_o=1 and iack[sel] SHALL pulse one clk_sys cycle if valid. pend[sel] SHALL clear.
REQ-026 ACK->WAIT_DROP on the next ce cycle. wb_ack_o and wb_dat_o SHALL be held while wb_stb_i=1.
REQ-027 WAIT_DROP->IDLE when wb_stb_i=0. wb_ack_o and wb_dat_o SHALL go to 0 on that same ce cycle.
REQ-028 If wb_stb_i drops during LATCH, go to IDLE, issue no iack, and leave pend unchanged.
REQ-029 Requests arriving after LATCH SHALL NOT change sel for the current cycle.
REQ-030 wb_dat_o SHALL be 0 whenever wb_ack_o=0, so outputs can be OR-bussed.

Reset
REQ-031 On wb_rst_i=1, independent of ce: state=IDLE; pend=0; mask_q=0; wb_irq_o=0; wb_ack_o=0; wb_dat_o=0; iack=0.
REQ-032 Reset mid-acknowledge SHALL abort with no iack pulse. After reset, a still-active level request SHALL re-pend on the first ce cycle.

Configuration
REQ-033 With macro VIC_EDGE_EN defined: pend[k] sets on a 0->1 ireq[k] transition, using an ireq history register cleared by reset. A level held high after acknowledge SHALL NOT re-pend.
REQ-034 Without VIC_EDGE_EN: pend[k] sets on every ce cycle that ireq[k]=1. A held level re-pends on the ce cycle after ACK.

Verification
REQ-035 N=2, ivec={16'o060,16'o274}, ireq=2'b11, mask=0, strobe -> wb_dat_o=16'o060, iack=2'b10; second strobe -> 16'o274, iack=2'b01.
REQ-036 Masking: mask=2'b10, ireq[1]=1 -> wb_irq_o stays 0. Writing mask=0 -> wb_irq_o=1 on the next ce cycle, with pend retained.
REQ-037 No request pending, strobe asserted -> wb_dat_o=SPUR_VEC, wb_ack_o=1, iack=0.
REQ-038 wb_stb_i drops in LATCH -> no iack, no ack, pend unchanged. wb_rst_i during ACK -> all outputs 0 on the next clk.
REQ-039 ireq[0] held high: with VIC_EDGE_EN, one acknowledge then wb_irq_o=0. Without it, wb_irq_o=1 again one ce cycle after ACK.
REQ-040 ce=1 only every 24th clk_sys -> FSM and pend advance only on ce, and each iack pulse is exactly one clk_sys wide.
